// File: rtl/mem_arb_pkg.sv
// Shared types and geometry for the two-client cache-line memory arbiter.
package mem_arb_pkg;

  localparam int LINE_W    = 256;
  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int OFFSET_W  = 5;
  localparam int CNT_W     = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    IREAD,
    DREAD,
    DWRITE,
    DONE
  } arb_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Line buffer, line-aligned address register and beat counter that turn one
// 256-bit line transfer into a four-beat 64-bit memory burst.
module cacheline_adaptor
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic [ADDR_W-OFFSET_W-1:0] load_tag_i,
  input  logic                       load_wdata_en_i,
  input  logic [LINE_W-1:0]          load_wdata_i,
  input  logic                       burst_read_i,
  input  logic                       burst_write_i,
  input  logic                       mem_resp_i,
  input  logic [BEAT_W-1:0]          mem_rdata_i,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [BEAT_W-1:0]          mem_wdata_o,
  output logic [LINE_W-1:0]          line_o,
  output logic                       last_beat_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              capture;
  logic [BEAT_W-1:0] beat_w [BURST_LEN];
  logic [BURST_LEN-1:0] beat_we;

  // Beats only count while a burst owns the bus; stray strobes are dropped.
  assign capture     = mem_resp_i && (burst_read_i || burst_write_i);
  assign last_beat_o = capture && (cnt_q == CNT_W'(BURST_LEN - 1));

  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_beat
    assign beat_w[gi]  = line_q[gi*BEAT_W +: BEAT_W];
    assign beat_we[gi] = capture && burst_read_i && (cnt_q == CNT_W'(gi));
  end

  always_comb begin
    addr_d = addr_q;
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = {load_tag_i, {OFFSET_W{1'b0}}};
      cnt_d  = '0;
      if (load_wdata_en_i) begin
        line_d = load_wdata_i;
      end
    end else if (capture) begin
      for (int b = 0; b < BURST_LEN; b++) begin
        if (beat_we[b]) begin
          line_d[b*BEAT_W +: BEAT_W] = mem_rdata_i;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = beat_w[cnt_q];
  assign line_o      = line_q;

endmodule

// File: rtl/mem_arbiter.sv
// Grant FSM arbitrating icache reads and dcache reads/writebacks onto a single
// burst memory port; one line transfer in flight at a time, never preempted.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter bit DPRIO  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_e                 state_q, state_d;
  logic                       dside_q, dside_d;
  logic                       grant, grant_wr, last_beat, d_req;
  logic [ADDR_W-OFFSET_W-1:0] grant_tag;
  logic [LINE_W-1:0]          line;

  // Offset bits never reach memory: bursts are always line aligned.
  wire unused_offset = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0]};

  assign d_req = d_read || d_write;

  always_comb begin
    state_d   = state_q;
    dside_d   = dside_q;
    grant     = 1'b0;
    grant_wr  = 1'b0;
    grant_tag = i_addr[ADDR_W-1:OFFSET_W];
    case (state_q)
      IDLE: begin
        if (d_req && (DPRIO || !i_read)) begin
          grant     = 1'b1;
          dside_d   = 1'b1;
          grant_tag = d_addr[ADDR_W-1:OFFSET_W];
          grant_wr  = d_write;
          state_d   = d_write ? DWRITE : DREAD;
        end else if (i_read) begin
          grant   = 1'b1;
          dside_d = 1'b0;
          state_d = IREAD;
        end
      end
      IREAD, DREAD, DWRITE: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dside_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dside_q <= dside_d;
    end
  end

  assign mem_read  = (state_q == IREAD) || (state_q == DREAD);
  assign mem_write = (state_q == DWRITE);
  assign i_resp    = (state_q == DONE) && !dside_q;
  assign d_resp    = (state_q == DONE) && dside_q;
  assign i_rdata   = line;
  assign d_rdata   = line;

  cacheline_adaptor #(
    .ADDR_W(ADDR_W)
  ) u_adaptor (
    .clk            (clk),
    .reset          (reset),
    .load_i         (grant),
    .load_tag_i     (grant_tag),
    .load_wdata_en_i(grant_wr),
    .load_wdata_i   (d_wdata),
    .burst_read_i   (mem_read),
    .burst_write_i  (mem_write),
    .mem_resp_i     (mem_resp),
    .mem_rdata_i    (mem_rdata),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .line_o         (line),
    .last_beat_o    (last_beat)
  );

`ifndef SYNTHESIS
  // Simultaneous dcache read and write is a client bug; the write still wins.
  a_no_dual_dreq: assert property (@(posedge clk) disable iff (!reset) !(d_read && d_write));
`endif

endmodule
